// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: latches a parallel pattern and shifts it out MSB-first,
// repeating for reps+1 bursts with an optional idle gap between bursts.
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);
    localparam int BIT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [BIT_W-1:0]   len_q, len_d;
    logic [REP_W-1:0]   burst_q, burst_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic               dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BIT_W-1:0]   eff_len;
    logic [WIDTH-1:0]   aligned;

    // Pattern is left-justified so the first bit always sits at the MSB of the shifter
    always_comb begin
        if (len == '0 || len > LEN_W'(WIDTH)) eff_len = BIT_W'(WIDTH);
        else                                  eff_len = BIT_W'(len);
        aligned = pattern << (BIT_W'(WIDTH) - eff_len);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        len_d   = len_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        dout_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SHIFT;
                    pat_d   = aligned;
                    sh_d    = aligned;
                    bit_d   = eff_len - 1'b1;
                    len_d   = eff_len;
                    burst_d = reps;
                    gap_d   = gap;
                    dout_d  = aligned[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_q != '0) begin
                    sh_d    = sh_q << 1;
                    bit_d   = bit_q - 1'b1;
                    dout_d  = sh_d[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (burst_q != '0) begin
                    burst_d = burst_q - 1'b1;
                    busy_d  = 1'b1;
                    if (gap_q != '0) begin
                        state_d = S_GAP;
                        gcnt_d  = gap_q;
                    end else begin
                        sh_d    = pat_q;
                        bit_d   = len_q - 1'b1;
                        dout_d  = pat_q[WIDTH-1];
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gcnt_q <= GAP_W'(1)) begin
                    state_d = S_SHIFT;
                    sh_d    = pat_q;
                    bit_d   = len_q - 1'b1;
                    dout_d  = pat_q[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    gcnt_d  = gcnt_q - 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            burst_q <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
